// File: rtl/mc_pi_sampler.sv
// Monte-Carlo quarter-circle sampler: counts points (x,y) in [0,1)^2 with x^2+y^2 < 1.
// Optional feature macro MC_PI_ABORT_EN adds an abort input that cancels a run in progress.
module mc_pi_sampler #(
   parameter int N_SAMPLES = 1024,
   parameter int FRAC_W    = 16,
   localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef MC_PI_ABORT_EN
   input  logic             abort,
`endif
   input  logic [31:0]      rnd1,
   input  logic [31:0]      rnd2,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] hits,
   output logic [CNT_W-1:0] issued
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int SQ_W = 2 * FRAC_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
   localparam logic [SQ_W:0]    ONE_SQ   = {1'b1, {SQ_W{1'b0}}};

   state_t            state, next_state;
   logic              abort_req, capture, clear_run, pipe_empty;
   logic              v1, v2, v3, hit3;
   logic [FRAC_W-1:0] x1, y1;
   logic [SQ_W-1:0]   xx2, yy2;
   logic [SQ_W:0]     sum2;
   logic [CNT_W-1:0]  acc;
   logic              unused_rnd_bits;

`ifdef MC_PI_ABORT_EN
   assign abort_req = abort && (state == RUN || state == DRAIN);
`else
   assign abort_req = 1'b0;
`endif

   assign capture    = (state == RUN) && !abort_req;
   assign clear_run  = (state == IDLE) && start;
   assign pipe_empty = !v1 && !v2 && !v3;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign sum2       = {1'b0, xx2} + {1'b0, yy2};
   // Only the top FRAC_W bits of each word are meaningful; the rest are deliberately dropped.
   assign unused_rnd_bits = ^{rnd1, rnd2};

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN: begin
            if (abort_req)               next_state = IDLE;
            else if (issued == LAST_IDX) next_state = DRAIN;
         end
         DRAIN: begin
            if (abort_req)       next_state = IDLE;
            else if (pipe_empty) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         issued <= '0;
         hits   <= '0;
         acc    <= '0;
      end else begin
         state <= next_state;
         if (clear_run)    issued <= '0;
         else if (capture) issued <= issued + CNT_W'(1);
         if (clear_run || abort_req) acc <= '0;
         else if (v3 && hit3)        acc <= acc + CNT_W'(1);
         // Publish on entry to DONE so hits is already final while done is high.
         if (state == DRAIN && next_state == DONE) hits <= acc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         x1   <= '0;
         y1   <= '0;
         xx2  <= '0;
         yy2  <= '0;
         hit3 <= 1'b0;
      end else begin
         v1 <= capture;
         v2 <= v1 && !abort_req;
         v3 <= v2 && !abort_req;
         if (capture) begin
            x1 <= rnd1[31 -: FRAC_W];
            y1 <= rnd2[31 -: FRAC_W];
         end
         if (v1) begin
            xx2 <= SQ_W'(x1) * SQ_W'(x1);
            yy2 <= SQ_W'(y1) * SQ_W'(y1);
         end
         // A point exactly on the unit circle counts as a miss.
         if (v2) hit3 <= (sum2 < ONE_SQ);
      end
   end

endmodule

// File: tb/tb_mc_pi_sampler.sv
// Scoreboard bench for mc_pi_sampler (N_SAMPLES=16, FRAC_W=16): expected hit counts are
// queued when a run is launched and checked when done pulses.
module tb_mc_pi_sampler;

   localparam int N  = 16;
   localparam int FW = 16;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
`ifdef MC_PI_ABORT_EN
   logic          abort = 1'b0;
`endif
   logic [31:0]   rnd1 = '0;
   logic [31:0]   rnd2 = '0;
   logic          busy, done;
   logic [CW-1:0] hits, issued;

   int            compared = 0;
   int            mismatched = 0;
   int            exp_q[$];
   int            last_hits = 0;
   logic [31:0]   pat1[N];
   logic [31:0]   pat2[N];

   mc_pi_sampler #(.N_SAMPLES(N), .FRAC_W(FW)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
`ifdef MC_PI_ABORT_EN
      .abort  (abort),
`endif
      .rnd1   (rnd1),
      .rnd2   (rnd2),
      .busy   (busy),
      .done   (done),
      .hits   (hits),
      .issued (issued)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: full-width arithmetic on the top FW bits of every captured word.
   function automatic int model_hits();
      longint unsigned x, y;
      int h;
      h = 0;
      for (int i = 0; i < N; i++) begin
         x = 64'(pat1[i] >> (32 - FW));
         y = 64'(pat2[i] >> (32 - FW));
         if (x * x + y * y < (64'd1 << (2 * FW))) h++;
      end
      return h;
   endfunction

   task automatic fill(input int kind);
      for (int i = 0; i < N; i++) begin
         case (kind)
            0:       begin pat1[i] = 32'h0;         pat2[i] = 32'h0;         end
            1:       begin pat1[i] = 32'hFFFF_FFFF; pat2[i] = 32'hFFFF_FFFF; end
            2:       begin pat1[i] = 32'hB504_0000; pat2[i] = 32'hB504_0000; end
            3:       begin pat1[i] = 32'hB505_0000; pat2[i] = 32'hB505_0000; end
            4: begin
               pat1[i] = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
               pat2[i] = pat1[i];
            end
            default: begin pat1[i] = $urandom;      pat2[i] = $urandom;      end
         endcase
      end
   endtask

   // Launches one run; pattern word k is present for capture edge k+1 after the start edge.
   task automatic run_pattern(input bit mid_start, output int done_cycle, output int done_count,
                              output logic busy_after, output logic [CW-1:0] obs_hits,
                              output logic [CW-1:0] obs_issued);
      int k;
      done_cycle = -1;
      done_count = 0;
      busy_after = 1'b1;
      obs_hits   = '0;
      obs_issued = '0;
      @(negedge clk);
      start = 1'b1;
      exp_q.push_back(model_hits());
      k = 0;
      while (k <= 40 && (done_cycle < 0 || k <= done_cycle + 2)) begin
         @(negedge clk);
         if (done) begin
            done_count++;
            if (done_cycle < 0) begin
               done_cycle = k;
               obs_hits   = hits;
               obs_issued = issued;
            end
         end
         if (done_cycle >= 0 && k == done_cycle + 1) busy_after = busy;
         start = mid_start && (k % 3 == 1) && (k < 12);
         rnd1  = (k < N) ? pat1[k] : $urandom;
         rnd2  = (k < N) ? pat2[k] : $urandom;
         k++;
      end
      start = 1'b0;
      rnd1  = '0;
      rnd2  = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ctrl: got busy=%b done=%b, expected 0 0", busy, done);
      end
      compared++;
      if (hits !== '0 || issued !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_counts: got hits=%0d issued=%0d, expected 0 0", hits, issued);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_busy: got %b, expected 0", busy);
      end
   endtask

   task automatic test_patterns();
      int dc, dn, ex;
      logic ba;
      logic [CW-1:0] oh, oi;
      for (int kind = 0; kind < 6; kind++) begin
         fill(kind);
         run_pattern(1'b0, dc, dn, ba, oh, oi);
         compared++;
         if (dc !== N + 4) begin
            mismatched++;
            $display("[TB] FAIL latency kind=%0d: got %0d, expected %0d", kind, dc, N + 4);
         end
         compared++;
         if (dn !== 1) begin
            mismatched++;
            $display("[TB] FAIL done_count kind=%0d: got %0d, expected 1", kind, dn);
         end
         compared++;
         if (ba !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL busy_after_done kind=%0d: got %b, expected 0", kind, ba);
         end
         compared++;
         if (oi !== CW'(N)) begin
            mismatched++;
            $display("[TB] FAIL issued kind=%0d: got %0d, expected %0d", kind, oi, N);
         end
         ex = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         compared++;
         if (ex < 0 || oh !== CW'(ex)) begin
            mismatched++;
            $display("[TB] FAIL hits kind=%0d: got %0d, expected %0d", kind, oh, ex);
         end
         last_hits = ex;
      end
   endtask

   task automatic test_back_to_back();
      int dc, dn, ex;
      logic ba;
      logic [CW-1:0] oh, oi;
      fill(4);
      run_pattern(1'b1, dc, dn, ba, oh, oi);
      compared++;
      if (dn !== 1 || dc !== N + 4) begin
         mismatched++;
         $display("[TB] FAIL midrun_start: got done_count=%0d at cycle %0d, expected 1 at %0d",
                  dn, dc, N + 4);
      end
      ex = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      compared++;
      if (ex < 0 || oh !== CW'(ex)) begin
         mismatched++;
         $display("[TB] FAIL alt_hits: got %0d, expected %0d", oh, ex);
      end
      last_hits = ex;
   endtask

   task automatic test_reset_mid_run();
      int seen, dc, dn, ex;
      logic ba;
      logic [CW-1:0] oh, oi;
      fill(0);
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start = 1'b0;
         rnd1  = pat1[k];
         rnd2  = pat2[k];
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midrun_reset_ctrl: got busy=%b done=%b, expected 0 0", busy, done);
      end
      compared++;
      if (hits !== '0 || issued !== '0) begin
         mismatched++;
         $display("[TB] FAIL midrun_reset_counts: got hits=%0d issued=%0d, expected 0 0",
                  hits, issued);
      end
      seen = 0;
      repeat (2) @(negedge clk) if (done) seen++;
      reset = 1'b1;
      repeat (25) @(negedge clk) if (done) seen++;
      compared++;
      if (seen !== 0) begin
         mismatched++;
         $display("[TB] FAIL midrun_reset_done: got %0d pulses, expected 0", seen);
      end
      run_pattern(1'b0, dc, dn, ba, oh, oi);
      ex = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      compared++;
      if (ex < 0 || oh !== CW'(ex) || dc !== N + 4) begin
         mismatched++;
         $display("[TB] FAIL rerun_after_reset: got hits=%0d at cycle %0d, expected %0d at %0d",
                  oh, dc, ex, N + 4);
      end
      last_hits = ex;
   endtask

`ifdef MC_PI_ABORT_EN
   task automatic test_abort();
      int seen;
      fill(1);
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         start = 1'b0;
         rnd1  = pat1[k];
         rnd2  = pat2[k];
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      compared++;
      if (busy !== 1'b0 || issued !== CW'(7)) begin
         mismatched++;
         $display("[TB] FAIL abort_state: got busy=%b issued=%0d, expected 0 7", busy, issued);
      end
      seen = 0;
      repeat (25) @(negedge clk) if (done) seen++;
      compared++;
      if (seen !== 0) begin
         mismatched++;
         $display("[TB] FAIL abort_done: got %0d pulses, expected 0", seen);
      end
      compared++;
      if (hits !== CW'(last_hits)) begin
         mismatched++;
         $display("[TB] FAIL abort_hits: got %0d, expected %0d", hits, last_hits);
      end
   endtask
`endif

   initial begin
      $display("[TB] mc_pi_sampler bench, N=%0d FRAC_W=%0d", N, FW);
      test_reset();
      test_patterns();
      test_back_to_back();
      test_reset_mid_run();
`ifdef MC_PI_ABORT_EN
      test_abort();
`endif
      compared++;
      if (exp_q.size() !== 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
